// File: rtl/iterative_divider_if.sv
// Handshake and operand bundle between execute dispatch and the iterative divider.
// The master side (dispatch) drives the request; the slave side (divider) returns
// busy/done status and the registered result.
interface iterative_divider_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             kill_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, kill_i, op_i, dividend_i, divisor_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, kill_i, op_i, dividend_i, divisor_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/iterative_divider.sv
// Multi-cycle radix-2 restoring divider for the RS5 execute stage (RV32M
// DIV/DIVU/REM/REMU). One quotient bit is produced per cycle; signs are stripped
// before the iterations and restored in a final fix-up state.
// Optional build macro RS5_DIV_EARLY_OUT_EN: skip the iterations when the divisor
// is zero or larger in magnitude than the dividend (result available in 3 cycles).
module iterative_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  iterative_divider_if.slave div_if
);

  typedef enum logic [1:0] {
    D_IDLE,
    D_INIT,
    D_CALC,
    D_SIGN
  } state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic             is_signed;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             dvs_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shift_w;
  logic [WIDTH:0]   trial_w;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
`ifdef RS5_DIV_EARLY_OUT_EN
  logic             early_out;
`endif

  // Operand magnitudes and sign bookkeeping, evaluated while in D_INIT. The
  // operands were latched raw into quo_q (dividend) and dvs_q (divisor).
  always_comb begin
    is_signed = ~op_q[0];
    dvd_neg   = is_signed & quo_q[WIDTH-1];
    dvs_neg   = is_signed & dvs_q[WIDTH-1];
    dvs_zero  = (dvs_q == '0);
    dvd_mag   = dvd_neg ? -quo_q : quo_q;
    dvs_mag   = dvs_neg ? -dvs_q : dvs_q;
`ifdef RS5_DIV_EARLY_OUT_EN
    early_out = dvs_zero | (dvs_mag > dvd_mag);
`endif
  end

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor and
  // keep the difference when it did not borrow. A zero divisor never borrows,
  // which is what yields an all-ones quotient and remainder == dividend.
  always_comb begin
    shift_w = {rem_q, quo_q[WIDTH-1]};
    trial_w = shift_w - {1'b0, dvs_q};
    rem_d   = shift_w[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial_w[WIDTH] || dvs_zero) begin
      rem_d = trial_w[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM and datapath registers; kill_i overrides everything except reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= D_IDLE;
      op_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (div_if.kill_i) begin
        state_q <= D_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          D_IDLE: begin
            if (div_if.start_i) begin
              op_q    <= div_if.op_i;
              quo_q   <= div_if.dividend_i;
              dvs_q   <= div_if.divisor_i;
              rem_q   <= '0;
              state_q <= D_INIT;
              busy_q  <= 1'b1;
            end
          end
          D_INIT: begin
            quo_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            rem_q     <= '0;
            neg_quo_q <= (dvd_neg ^ dvs_neg) & ~dvs_zero;
            neg_rem_q <= dvd_neg;
            cnt_q     <= CNT_W'(WIDTH - 1);
            state_q   <= D_CALC;
`ifdef RS5_DIV_EARLY_OUT_EN
            if (early_out) begin
              quo_q   <= dvs_zero ? '1 : '0;
              rem_q   <= dvd_mag;
              state_q <= D_SIGN;
            end
`endif
          end
          D_CALC: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == '0) begin
              state_q <= D_SIGN;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          D_SIGN: begin
            if (op_q[1]) begin
              result_q <= neg_rem_q ? -rem_q : rem_q;
            end else begin
              result_q <= neg_quo_q ? -quo_q : quo_q;
            end
            done_q  <= 1'b1;
            state_q <= D_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= D_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign div_if.busy_o   = busy_q;
  assign div_if.done_o   = done_q;
  assign div_if.result_o = result_q;

endmodule
